// File: rtl/alu_req_sequencer.sv
// Two-requester round-robin front end for a shared 1-cycle registered ALU.
// Optional macro ALU_SEQ_OP_COUNT_EN adds a 16-bit response handshake counter (o_op_count).
module alu_req_sequencer #(
    parameter int N = 4,
    parameter int M = 8,
    parameter int K = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_req0_valid,
    output logic         o_req0_ready,
    input  logic [N-1:0] i_req0_op,
    input  logic [M-1:0] i_req0_arg_A,
    input  logic [M-1:0] i_req0_arg_B,
    input  logic         i_req1_valid,
    output logic         o_req1_ready,
    input  logic [N-1:0] i_req1_op,
    input  logic [M-1:0] i_req1_arg_A,
    input  logic [M-1:0] i_req1_arg_B,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic         o_rsp_id,
    output logic [K-1:0] o_rsp_result,
    output logic [3:0]   o_rsp_status,
    output logic [N-1:0] o_alu_op,
    output logic [M-1:0] o_alu_arg_A,
    output logic [M-1:0] o_alu_arg_B,
    input  logic [K-1:0] i_alu_result,
    input  logic [3:0]   i_alu_status,
`ifdef ALU_SEQ_OP_COUNT_EN
    output logic [15:0]  o_op_count,
`endif
    output logic         o_busy
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t         state_reg, state_next;
    logic           last_grant_reg;
    logic [N-1:0]   op_reg;
    logic [M-1:0]   arg_a_reg, arg_b_reg;
    logic           id_reg;
    logic [K-1:0]   result_reg;
    logic [3:0]     status_reg;

    logic           grant0, grant1, accept;
    logic [N-1:0]   sel_op;
    logic [M-1:0]   sel_a, sel_b;
    logic           sel_supported;

    // On a tie the requester that was not granted last time wins.
    assign grant0 = i_req0_valid & (~i_req1_valid | last_grant_reg);
    assign grant1 = i_req1_valid & ~grant0;

    always_comb begin
        state_next   = state_reg;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        accept       = 1'b0;
        sel_op       = grant1 ? i_req1_op    : i_req0_op;
        sel_a        = grant1 ? i_req1_arg_A : i_req0_arg_A;
        sel_b        = grant1 ? i_req1_arg_B : i_req0_arg_B;
        sel_supported = (sel_op[N-1:N-2] == 2'b00);
        case (state_reg)
            IDLE: begin
                o_req0_ready = grant0;
                o_req1_ready = grant1;
                accept       = grant0 | grant1;
                if (accept)
                    state_next = sel_supported ? EXEC : RESP;
            end
            EXEC: state_next = CAPT;
            CAPT: state_next = RESP;
            RESP: if (i_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            op_reg         <= '0;
            arg_a_reg      <= '0;
            arg_b_reg      <= '0;
            id_reg         <= 1'b0;
            result_reg     <= '0;
            status_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg         <= sel_op;
                arg_a_reg      <= sel_a;
                arg_b_reg      <= sel_b;
                id_reg         <= grant1;
                last_grant_reg <= grant1;
                if (!sel_supported) begin
                    result_reg <= '0;
                    status_reg <= 4'b1000;
                end
            end
            // Bit 3 is reserved for the unsupported-op flag owned by this block.
            if (state_reg == CAPT) begin
                result_reg <= i_alu_result;
                status_reg <= i_alu_status & 4'b0111;
            end
        end
    end

`ifdef ALU_SEQ_OP_COUNT_EN
    logic [15:0] op_count_reg;
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            op_count_reg <= '0;
        else if (o_rsp_valid && i_rsp_ready)
            op_count_reg <= op_count_reg + 16'd1;
    end
    assign o_op_count = op_count_reg;
`endif

    logic alu_drive;
    assign alu_drive    = (state_reg == EXEC) || (state_reg == CAPT);
    assign o_alu_op     = alu_drive ? op_reg    : '0;
    assign o_alu_arg_A  = alu_drive ? arg_a_reg : '0;
    assign o_alu_arg_B  = alu_drive ? arg_b_reg : '0;
    assign o_rsp_valid  = (state_reg == RESP);
    assign o_rsp_id     = id_reg;
    assign o_rsp_result = result_reg;
    assign o_rsp_status = status_reg;
    assign o_busy       = (state_reg != IDLE);
endmodule
